// File: rtl/avm_uart_stream_master_if.sv
// avm_uart_stream_master_if: Avalon-MM bus to the UART plus the valid/ready
// frame handshakes to the compute core, bundled for the stream master.
// master = the bridge's view, slave = the UART/core side.
interface avm_uart_stream_master_if #(
  parameter int IN_BYTES  = 32,
  parameter int OUT_BYTES = 31
);
  logic [4:0]             avm_address;
  logic                   avm_read;
  logic [31:0]            avm_readdata;
  logic                   avm_write;
  logic [31:0]            avm_writedata;
  logic                   avm_waitrequest;
  logic                   core_in_valid;
  logic                   core_in_ready;
  logic [IN_BYTES*8-1:0]  core_in_data;
  logic                   core_out_valid;
  logic                   core_out_ready;
  logic [OUT_BYTES*8-1:0] core_out_data;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata,
    input  avm_readdata, avm_waitrequest,
    output core_in_valid, core_in_data, core_out_ready,
    input  core_in_ready, core_out_valid, core_out_data
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata,
    output avm_readdata, avm_waitrequest,
    input  core_in_valid, core_in_data, core_out_ready,
    output core_in_ready, core_out_valid, core_out_data
  );
endinterface

// File: rtl/avm_uart_stream_master.sv
// avm_uart_stream_master: Avalon-MM master that polls a UART, gathers IN_BYTES
// rx bytes into a frame for the compute core, and streams the core's
// OUT_BYTES result back out through the UART tx register, MSB byte first.
// Optional feature macro: UART_CKSUM_EN appends one XOR checksum byte to
// every transmitted result frame.
//
// state    | meaning
// RX_POLL  | reading status, waiting for an rx byte
// RX_READ  | reading one rx byte into the frame
// CORE_IN  | offering the input frame to the core
// CORE_OUT | waiting for the core's result
// TX_POLL  | reading status, waiting for tx space
// TX_WRITE | writing one result byte
// DONE     | frame finished, bump frame counter
module avm_uart_stream_master #(
  parameter int         IN_BYTES    = 32,
  parameter int         OUT_BYTES   = 31,
  parameter logic [4:0] RX_ADDR     = 5'd0,
  parameter logic [4:0] TX_ADDR     = 5'd4,
  parameter logic [4:0] STATUS_ADDR = 5'd8,
  parameter int         RX_OK_BIT   = 7,
  parameter int         TX_OK_BIT   = 6
) (
  input  logic                     avm_clk,
  input  logic                     avm_rst_n,
  avm_uart_stream_master_if.master bus,
  output logic [15:0]              frame_count
);

  localparam int IN_W  = IN_BYTES * 8;
  localparam int OUT_W = OUT_BYTES * 8;
`ifdef UART_CKSUM_EN
  localparam int TX_BYTES = OUT_BYTES + 1;
`else
  localparam int TX_BYTES = OUT_BYTES;
`endif
  localparam int CNT_MAX = (IN_BYTES > TX_BYTES) ? IN_BYTES : TX_BYTES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(IN_BYTES - 1);
  localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(TX_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    RX_POLL, RX_READ, CORE_IN, CORE_OUT, TX_POLL, TX_WRITE, DONE
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             read_q;
  logic             write_q;
  logic [4:0]       address_q;
  logic [31:0]      writedata_q;
  logic             in_valid_q;
  logic             out_ready_q;
  logic [15:0]      frame_count_q;
  logic [IN_W-1:0]  frame_q;
  logic [IN_W-1:0]  frame_d;
  logic [OUT_W-1:0] result_q;
  logic [7:0]       tx_byte_d;
`ifdef UART_CKSUM_EN
  logic [7:0]       cksum_q;
`endif

  // Next frame contents on an rx byte, and the byte to send on the next tx write.
  always_comb begin
    frame_d       = frame_q << 8;
    frame_d[7:0]  = bus.avm_readdata[7:0];
    tx_byte_d     = result_q[OUT_W-1 -: 8];
`ifdef UART_CKSUM_EN
    if (cnt_q == TX_LAST) tx_byte_d = cksum_q;
`endif
  end

  // Sequencer with registered bus/handshake outputs. A completing access
  // advances the state and, where the next state needs the bus, launches the
  // next access on the same edge so a byte costs two cycles with no waits.
  always_ff @(posedge avm_clk) begin
    if (!avm_rst_n) begin
      state_q       <= RX_POLL;
      cnt_q         <= '0;
      read_q        <= 1'b0;
      write_q       <= 1'b0;
      address_q     <= '0;
      writedata_q   <= '0;
      in_valid_q    <= 1'b0;
      out_ready_q   <= 1'b0;
      frame_count_q <= '0;
      frame_q       <= '0;
      result_q      <= '0;
`ifdef UART_CKSUM_EN
      cksum_q       <= '0;
`endif
    end else begin
      case (state_q)
        RX_POLL: begin
          if (!read_q) begin
            read_q    <= 1'b1;
            address_q <= STATUS_ADDR;
          end else if (!bus.avm_waitrequest && bus.avm_readdata[RX_OK_BIT]) begin
            address_q <= RX_ADDR;
            state_q   <= RX_READ;
          end
        end
        RX_READ: begin
          if (!bus.avm_waitrequest) begin
            frame_q <= frame_d;
            if (cnt_q == RX_LAST) begin
              cnt_q      <= '0;
              read_q     <= 1'b0;
              in_valid_q <= 1'b1;
              state_q    <= CORE_IN;
            end else begin
              cnt_q     <= cnt_q + CNT_ONE;
              address_q <= STATUS_ADDR;
              state_q   <= RX_POLL;
            end
          end
        end
        CORE_IN: begin
          if (bus.core_in_ready) begin
            in_valid_q  <= 1'b0;
            out_ready_q <= 1'b1;
            state_q     <= CORE_OUT;
          end
        end
        CORE_OUT: begin
          if (bus.core_out_valid) begin
            out_ready_q <= 1'b0;
            result_q    <= bus.core_out_data;
`ifdef UART_CKSUM_EN
            cksum_q     <= '0;
`endif
            read_q      <= 1'b1;
            address_q   <= STATUS_ADDR;
            state_q     <= TX_POLL;
          end
        end
        TX_POLL: begin
          if (!bus.avm_waitrequest && bus.avm_readdata[TX_OK_BIT]) begin
            read_q      <= 1'b0;
            write_q     <= 1'b1;
            address_q   <= TX_ADDR;
            writedata_q <= {24'h0, tx_byte_d};
            state_q     <= TX_WRITE;
          end
        end
        TX_WRITE: begin
          if (!bus.avm_waitrequest) begin
            write_q  <= 1'b0;
            result_q <= result_q << 8;
`ifdef UART_CKSUM_EN
            cksum_q  <= cksum_q ^ writedata_q[7:0];
`endif
            if (cnt_q == TX_LAST) begin
              cnt_q   <= '0;
              state_q <= DONE;
            end else begin
              cnt_q     <= cnt_q + CNT_ONE;
              read_q    <= 1'b1;
              address_q <= STATUS_ADDR;
              state_q   <= TX_POLL;
            end
          end
        end
        DONE: begin
          frame_count_q <= frame_count_q + 16'd1;
          cnt_q         <= '0;
          read_q        <= 1'b1;
          address_q     <= STATUS_ADDR;
          state_q       <= RX_POLL;
        end
        default: begin
          read_q  <= 1'b0;
          write_q <= 1'b0;
          state_q <= RX_POLL;
        end
      endcase
    end
  end

  assign bus.avm_address    = address_q;
  assign bus.avm_read       = read_q;
  assign bus.avm_write      = write_q;
  assign bus.avm_writedata  = writedata_q;
  assign bus.core_in_valid  = in_valid_q;
  assign bus.core_in_data   = frame_q;
  assign bus.core_out_ready = out_ready_q;
  assign frame_count        = frame_count_q;

endmodule

// File: tb/tb_avm_uart_stream_master.sv
// tb_avm_uart_stream_master: directed bench with a UART slave model that
// inserts random wait states, plus a read/write exclusivity checker.
`timescale 1ns/1ps
module tb_avm_uart_stream_master;
  localparam int IN_BYTES  = 4;
  localparam int OUT_BYTES = 2;
`ifdef UART_CKSUM_EN
  localparam int TX_N = OUT_BYTES + 1;
`else
  localparam int TX_N = OUT_BYTES;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  avm_uart_stream_master_if #(.IN_BYTES(IN_BYTES), .OUT_BYTES(OUT_BYTES)) bus ();

  avm_uart_stream_master #(.IN_BYTES(IN_BYTES), .OUT_BYTES(OUT_BYTES)) dut (
    .avm_clk     (clk),
    .avm_rst_n   (rst_n),
    .bus         (bus),
    .frame_count (frame_count)
  );

  int total = 0;
  int bad   = 0;

  // UART model state
  logic [7:0]  rx_q[$];
  logic [31:0] tx_log[$];
  int          rx_hold = 0;
  int          rx_blocked = 0;
  int          blocked_at_first = -1;
  bit          first_rd_seen = 1'b0;
  bit          tx_en = 1'b1;
  bit          force_wait = 1'b0;
  bit          forced_acc = 1'b0;
  bit          forced_seen = 1'b0;
  bit          forced_stable = 1'b0;
  int          bad_access = 0;
  bit          in_acc = 1'b0;
  int          wcnt = 0;
  logic [4:0]  s_addr;
  logic        s_rd, s_wr;
  logic [31:0] s_wd;
  bit          acc_stable;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // UART slave: decide wait states per access, answer on the completing cycle.
  always @(negedge clk) begin
    if (!(bus.avm_read || bus.avm_write)) begin
      in_acc = 1'b0;
      bus.avm_waitrequest = 1'b0;
      bus.avm_readdata = 32'hA5A5_A5FF;
    end else begin
      if (!in_acc) begin
        in_acc = 1'b1;
        s_addr = bus.avm_address;
        s_rd = bus.avm_read;
        s_wr = bus.avm_write;
        s_wd = bus.avm_writedata;
        acc_stable = 1'b1;
        if (bus.avm_write && force_wait) begin
          wcnt = 3;
          force_wait = 1'b0;
          forced_acc = 1'b1;
          forced_seen = 1'b1;
        end else begin
          wcnt = int'($urandom_range(4, 0));
        end
      end else begin
        if (bus.avm_address !== s_addr || bus.avm_read !== s_rd ||
            bus.avm_write !== s_wr || bus.avm_writedata !== s_wd)
          acc_stable = 1'b0;
        if (wcnt > 0) wcnt--;
      end
      bus.avm_waitrequest = (wcnt != 0);
      bus.avm_readdata = 32'hA5A5_A5FF;
      if (wcnt == 0) begin
        total++;
        assert (acc_stable) else begin
          bad++;
          $error("FAIL hold_stable: observed=0 expected=1 addr=%0h", s_addr);
        end
        if (forced_acc) begin
          forced_stable = acc_stable;
          forced_acc = 1'b0;
        end
        if (s_rd) begin
          if (s_addr == 5'd8) begin
            logic [31:0] st;
            st = 32'h5A5A_5A15;
            if (rx_q.size() > 0 && rx_hold == 0) st[7] = 1'b1;
            else if (rx_hold > 0) begin
              rx_hold--;
              rx_blocked++;
            end
            if (tx_en) st[6] = 1'b1;
            bus.avm_readdata = st;
          end else if (s_addr == 5'd0 && rx_q.size() > 0) begin
            if (!first_rd_seen) begin
              first_rd_seen = 1'b1;
              blocked_at_first = rx_blocked;
            end
            bus.avm_readdata = {24'h3C3C3C, rx_q.pop_front()};
          end else begin
            bad_access++;
          end
        end else begin
          if (s_addr == 5'd4) tx_log.push_back(s_wd);
          else bad_access++;
        end
        in_acc = 1'b0;
      end
    end
  end

  // Avalon read and write must never be asserted together.
  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      assert (!(bus.avm_read && bus.avm_write)) else begin
        bad++;
        $error("FAIL rw_exclusive: observed read=%0b write=%0b expected not both",
               bus.avm_read, bus.avm_write);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected finish total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic check_reset(input string tag);
    check({tag, "_read"}, 32'(bus.avm_read), 32'd0);
    check({tag, "_write"}, 32'(bus.avm_write), 32'd0);
    check({tag, "_address"}, 32'(bus.avm_address), 32'd0);
    check({tag, "_writedata"}, bus.avm_writedata, 32'd0);
    check({tag, "_in_valid"}, 32'(bus.core_in_valid), 32'd0);
    check({tag, "_out_ready"}, 32'(bus.core_out_ready), 32'd0);
    check({tag, "_frame_count"}, 32'(frame_count), 32'd0);
  endtask

  task automatic wait_in_valid(input string tag);
    int n = 0;
    while (bus.core_in_valid !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_in_valid_seen"}, 32'(bus.core_in_valid), 32'd1);
  endtask

  task automatic wait_tx(input int cnt, input string tag);
    int n = 0;
    while (tx_log.size() < cnt && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_tx_count"}, 32'(tx_log.size()), 32'(cnt));
  endtask

  task automatic wait_fc(input logic [15:0] val, input string tag);
    int n = 0;
    while (frame_count !== val && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_frame_count"}, 32'(frame_count), 32'(val));
  endtask

  task automatic core_exchange(input logic [15:0] result);
    bus.core_in_ready = 1'b1;
    @(negedge clk);
    bus.core_in_ready = 1'b0;
    bus.core_out_data = result;
    bus.core_out_valid = 1'b1;
    @(negedge clk);
    bus.core_out_valid = 1'b0;
    bus.core_out_data = 16'h0;
  endtask

  logic [7:0] exp_a[3] = '{8'hAB, 8'hCD, 8'h66};
  logic [7:0] exp_c[3] = '{8'h00, 8'hFF, 8'hFF};
  bit ok;

  initial begin
    bus.core_in_ready  = 1'b0;
    bus.core_out_valid = 1'b0;
    bus.core_out_data  = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("rst0");

    // Frame A: rx status held off for 10 polls, then 12 34 56 78.
    rx_q = '{8'h12, 8'h34, 8'h56, 8'h78};
    rx_hold = 10;
    tx_en = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    check("a_first_poll_read", 32'(bus.avm_read), 32'd1);
    check("a_first_poll_addr", 32'(bus.avm_address), 32'd8);
    wait_in_valid("a");
    check("a_blocked_polls", 32'(rx_blocked), 32'd10);
    check("a_first_rx_after_hold", 32'(blocked_at_first), 32'd10);
    check("a_in_data", bus.core_in_data, 32'h1234_5678);
    check("a_out_ready_idle", 32'(bus.core_out_ready), 32'd0);
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!(bus.core_in_valid === 1'b1 && bus.core_in_data === 32'h1234_5678)) ok = 1'b0;
    end
    check("a_in_valid_held", 32'(ok), 32'd1);

    tx_en = 1'b0;
    force_wait = 1'b1;
    bus.core_in_ready = 1'b1;
    @(negedge clk);
    bus.core_in_ready = 1'b0;
    check("a_in_valid_drop", 32'(bus.core_in_valid), 32'd0);
    check("a_out_ready_up", 32'(bus.core_out_ready), 32'd1);
    bus.core_out_data = 16'hABCD;
    bus.core_out_valid = 1'b1;
    @(negedge clk);
    bus.core_out_valid = 1'b0;
    bus.core_out_data = 16'h0;
    check("a_out_ready_drop", 32'(bus.core_out_ready), 32'd0);
    repeat (12) @(negedge clk);
    check("a_tx_blocked_writes", 32'(tx_log.size()), 32'd0);
    check("a_tx_polling", {26'd0, bus.avm_read, bus.avm_address}, {26'd0, 1'b1, 5'd8});
    tx_en = 1'b1;
    wait_tx(TX_N, "a");
    for (int i = 0; i < TX_N; i++)
      check($sformatf("a_tx_byte%0d", i), tx_log[i], {24'h0, exp_a[i]});
    check("a_forced_wait_seen", 32'(forced_seen), 32'd1);
    check("a_forced_wait_stable", 32'(forced_stable), 32'd1);
    wait_fc(16'd1, "a");

    // Frame B: reset lands in the middle of the result transmission.
    tx_log.delete();
    rx_q = '{8'hA5, 8'h01, 8'hFF, 8'h00};
    wait_in_valid("b");
    check("b_in_data", bus.core_in_data, 32'hA501_FF00);
    core_exchange(16'h1234);
    wait_tx(1, "b");
    check("b_tx_byte0", tx_log[0], 32'h0000_0012);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("b_rst");

    // Frame C: counter preloaded to its wrap value.
    tx_log.delete();
    rx_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    check("c_first_poll_read", 32'(bus.avm_read), 32'd1);
    check("c_first_poll_addr", 32'(bus.avm_address), 32'd8);
    force dut.frame_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_count_q;
    @(negedge clk);
    check("c_preload", 32'(frame_count), 32'h0000_FFFF);
    rx_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    wait_in_valid("c");
    check("c_in_data", bus.core_in_data, 32'h0102_0304);
    core_exchange(16'h00FF);
    wait_tx(TX_N, "c");
    for (int i = 0; i < TX_N; i++)
      check($sformatf("c_tx_byte%0d", i), tx_log[i], {24'h0, exp_c[i]});
    wait_fc(16'd0, "c");
    repeat (4) @(negedge clk);
    check("c_tx_no_extra", 32'(tx_log.size()), 32'(TX_N));
    check("rx_all_consumed", 32'(rx_q.size()), 32'd0);
    check("bad_access", 32'(bad_access), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
